// File: rtl/axis_pkt_rr_sched.sv
// Packet-level round-robin scheduler: grants one whole AXI-stream packet at a time
// to one of NUM requesters and passes its beats through to the shared output.
module axis_pkt_rr_sched #(
    parameter int NUM   = 4,
    parameter int DSIZE = 8,
    parameter int IDW   = 2
) (
    input  logic                 sys_clock,
    input  logic                 sys_rst,
    input  logic [NUM*DSIZE-1:0] s_tdata,
    input  logic [NUM-1:0]       s_tvalid,
    input  logic [NUM-1:0]       s_tlast,
    output logic [NUM-1:0]       s_tready,
    output logic [DSIZE-1:0]     m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic [15:0]          pkt_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [15:0]    pkt_cnt_q, pkt_cnt_d;

    logic           sel_found;
    logic [IDW-1:0] sel_idx;
    logic [IDW-1:0] cand;

    // Search ptr+1, ptr+2, ... modulo NUM; the first requester found wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM);
            if (!sel_found && s_tvalid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        pkt_cnt_d = pkt_cnt_q;
        m_tdata   = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        s_tready  = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    state_d = BURST;
                end
            end
            BURST: begin
                m_tdata            = s_tdata[grant_q*DSIZE +: DSIZE];
                m_tvalid           = s_tvalid[grant_q];
                m_tlast            = s_tlast[grant_q];
                s_tready[grant_q]  = m_tready;
                // The grant is released only by the tlast handshake of the locked stream.
                if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
                    ptr_d     = grant_q;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(NUM - 1);
            grant_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == BURST);
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_rr_sched.sv
// Scoreboard bench for axis_pkt_rr_sched: per-stream beat queues, a grant-order queue
// and packet-spacing checks, all consumed by an output monitor.
module tb_axis_pkt_rr_sched;

    typedef logic [8:0] beat_t;

    logic        sys_clock;
    logic        sys_rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] pkt_cnt;

    axis_pkt_rr_sched #(.NUM(4), .DSIZE(8), .IDW(2)) dut (
        .sys_clock (sys_clock),
        .sys_rst   (sys_rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    initial begin
        sys_clock = 1'b0;
        forever #5 sys_clock = ~sys_clock;
    end

    beat_t src_q [4][$];
    beat_t exp_q [4][$];
    int    exp_grant_q[$];
    int    seq_cnt [4];
    int    exp_pkt;
    int    n_checks;
    int    n_fail;
    int    mon_beats;
    int    cyc;
    bit    drv_en;
    bit    gap_en;
    bit    rand_ready;
    bit    period_en;
    bit    period_first;
    int    period_exp;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue one packet of len beats on stream s; the same beats become its expected output.
    task automatic applyStimulus(input int s, input int len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b[7:0] = 8'((s << 6) | (seq_cnt[s] & 63));
            b[8]   = (j == len - 1);
            seq_cnt[s]++;
            src_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
        exp_pkt++;
    endtask

    task automatic waitDone(input string name, input int bound);
        bit done;
        done = 1'b0;
        for (int c = 0; c < bound && !done; c++) begin
            @(posedge sys_clock); #2;
            done = !busy && exp_grant_q.size() == 0;
            for (int i = 0; i < 4; i++)
                if (src_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
        end
        checkOutput({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic waitBeat(input int bound);
        int snap;
        snap = mon_beats;
        for (int c = 0; c < bound && mon_beats == snap; c++) begin
            @(posedge sys_clock); #2;
        end
        checkOutput("wait_beat_timeout", 32'(mon_beats > snap), 32'd1);
    endtask

    // Source driver: inputs change 1 time unit after the rising edge, handshakes sampled at negedge.
    initial begin
        logic [3:0] hs;
        beat_t      b;
        forever begin
            @(negedge sys_clock);
            hs = s_tvalid & s_tready;
            @(posedge sys_clock); #1;
            if (drv_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                    if (!s_tvalid[i] || hs[i]) begin
                        if (src_q[i].size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                            b = src_q[i][0];
                            s_tvalid[i]        = 1'b1;
                            s_tdata[i*8 +: 8]  = b[7:0];
                            s_tlast[i]         = b[8];
                        end else begin
                            s_tvalid[i] = 1'b0;
                            s_tlast[i]  = 1'b0;
                        end
                    end
                end
                if (rand_ready) m_tready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Output monitor: every accepted beat is popped from its stream's queue and compared.
    initial begin
        bit    in_pkt;
        int    cur_g;
        int    last_start;
        int    g;
        beat_t e;
        in_pkt = 1'b0;
        cur_g = 0;
        last_start = 0;
        forever begin
            @(negedge sys_clock);
            cyc++;
            if (sys_rst) begin
                in_pkt = 1'b0;
            end else begin
                if (!busy) begin
                    checkOutput("idle_m_tvalid", 32'(m_tvalid), 32'd0);
                    checkOutput("idle_s_tready", 32'(s_tready), 32'd0);
                end else begin
                    checkOutput("burst_s_tready", 32'(s_tready), 32'(4'(m_tready) << grant_id));
                end
                if (m_tvalid && m_tready) begin
                    g = int'(grant_id);
                    if (in_pkt) checkOutput("no_interleave", 32'(g), 32'(cur_g));
                    if (!in_pkt) begin
                        if (exp_grant_q.size() > 0) checkOutput("grant_order", 32'(g), 32'(exp_grant_q.pop_front()));
                        if (period_en && !period_first) checkOutput("pkt_spacing", 32'(cyc - last_start), 32'(period_exp));
                        period_first = 1'b0;
                        last_start = cyc;
                        cur_g = g;
                    end
                    if (exp_q[g].size() == 0) begin
                        checkOutput("unexpected_beat", 32'(exp_q[g].size()), 32'd1);
                    end else begin
                        e = exp_q[g].pop_front();
                        checkOutput("beat_last_data", {23'd0, m_tlast, m_tdata}, {23'd0, e});
                    end
                    in_pkt = !m_tlast;
                    mon_beats++;
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0; mon_beats = 0; cyc = 0; exp_pkt = 0;
        for (int i = 0; i < 4; i++) seq_cnt[i] = 0;
        drv_en = 1'b0; gap_en = 1'b0; rand_ready = 1'b0;
        period_en = 1'b0; period_first = 1'b1; period_exp = 0;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clock);
        #2 sys_rst = 1'b0;
        drv_en = 1'b1;

        $display("[TB] test 1: reset state, no requests");
        repeat (20) @(posedge sys_clock);
        @(negedge sys_clock);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("t1_s_tready", 32'(s_tready), 32'd0);
        checkOutput("t1_pkt_cnt", 32'(pkt_cnt), 32'd0);
        checkOutput("t1_grant_id", 32'(grant_id), 32'd0);

        $display("[TB] test 2: all streams, 3-beat packets");
        @(posedge sys_clock); #2;
        period_en = 1'b1; period_first = 1'b1; period_exp = 4;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 4; s++) begin
                applyStimulus(s, 3);
                exp_grant_q.push_back(s);
            end
        waitDone("t2", 200);
        checkOutput("t2_pkt_cnt", 32'(pkt_cnt), 32'd8);

        $display("[TB] test 3: stream 2 only, single-beat packets");
        period_first = 1'b1; period_exp = 2;
        for (int p = 0; p < 6; p++) begin
            applyStimulus(2, 1);
            exp_grant_q.push_back(2);
        end
        waitDone("t3", 200);
        checkOutput("t3_pkt_cnt", 32'(pkt_cnt), 32'd14);
        period_en = 1'b0;

        $display("[TB] test 4: stream 0 requests while stream 1 is mid-packet");
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(0);
        applyStimulus(1, 4);
        waitBeat(50);
        applyStimulus(0, 3);
        @(negedge sys_clock);
        checkOutput("t4_grant_held", 32'(grant_id), 32'd1);
        waitDone("t4", 200);
        checkOutput("t4_pkt_cnt", 32'(pkt_cnt), 32'd16);

        $display("[TB] test 5: random ready and source gaps, 1000 packets");
        gap_en = 1'b1; rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++)
            applyStimulus($urandom_range(0, 3), $urandom_range(1, 4));
        waitDone("t5", 60000);
        checkOutput("t5_pkt_cnt", 32'(pkt_cnt), 32'(16'(exp_pkt)));
        gap_en = 1'b0; rand_ready = 1'b0;
        @(posedge sys_clock); #2 m_tready = 1'b1;

        $display("[TB] test 6: reset during beat 2 of a 5-beat packet");
        applyStimulus(0, 5);
        exp_pkt--;
        waitBeat(50);
        sys_rst = 1'b1;
        drv_en = 1'b0;
        s_tvalid = '0; s_tlast = '0;
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        @(posedge sys_clock);
        @(negedge sys_clock);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_s_tready", 32'(s_tready), 32'd0);
        checkOutput("t6_grant_id", 32'(grant_id), 32'd0);
        checkOutput("t6_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("t6_pkt_cnt", 32'(pkt_cnt), 32'd0);
        @(posedge sys_clock); #2;
        sys_rst = 1'b0;
        drv_en = 1'b1;
        exp_pkt = 0;
        period_en = 1'b1; period_first = 1'b1; period_exp = 3;
        for (int s = 3; s >= 0; s--) applyStimulus(s, 2);
        for (int s = 0; s < 4; s++) exp_grant_q.push_back(s);
        waitDone("t6", 200);
        checkOutput("t6_pkt_cnt_after", 32'(pkt_cnt), 32'd4);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
